// File: rtl/avalon_master_sequencer.sv
// avalon_master_sequencer: valid/ready command stream to Avalon-MM initiator, one transaction in flight; read timeout enabled by AVALON_MASTER_TIMEOUT_EN
module avalon_master_sequencer #(
  parameter int ADDRWIDTH = 2,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRWIDTH-1:0] cmd_address,
  input  logic [DATAWIDTH-1:0] cmd_data,
  output logic                 read,
  output logic                 write,
  output logic [ADDRWIDTH-1:0] address,
  output logic [DATAWIDTH-1:0] data_out,
  input  logic                 read_valid,
  input  logic [DATAWIDTH-1:0] data_in,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATAWIDTH-1:0] rsp_data,
  output logic                 rsp_error,
  output logic                 busy
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;
  state_t state;
  logic expired;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
`ifdef AVALON_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] count;
  assign expired = count == CW'(TIMEOUT - 1);
  // Wait-cycle counter is held at zero outside WAIT so it starts cleared on entry; error flag tracks the last read outcome
  always_ff @(posedge clk)
    if (reset) begin
      count <= '0;
      rsp_error <= 1'b0;
    end else begin
      count <= state == WAIT ? count + 1'b1 : '0;
      if (state == WAIT && (read_valid || expired)) rsp_error <= !read_valid;
    end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign expired = 1'b0;
  assign rsp_error = 1'b0;
`endif
  // Transaction sequencer with registered bus strobes and response
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      read <= 1'b0;
      write <= 1'b0;
      address <= '0;
      data_out <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
    end else
      case (state)
        IDLE:
          if (cmd_valid) begin
            address <= cmd_address;
            data_out <= cmd_data;
            write <= cmd_write;
            read <= !cmd_write;
            state <= cmd_write ? WRITE : READ;
          end
        WRITE: begin
          write <= 1'b0;
          state <= IDLE;
        end
        READ: begin
          read <= 1'b0;
          state <= WAIT;
        end
        WAIT:
          if (read_valid || expired) begin
            rsp_data <= read_valid ? data_in : '0;
            rsp_valid <= 1'b1;
            state <= RESP;
          end
        RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_avalon_master_sequencer.sv
// tb_avalon_master_sequencer: directed and randomized checks against a register-file model
module tb_avalon_master_sequencer;
  localparam int AW = 2;
  localparam int DW = 32;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_address = '0;
  logic [DW-1:0] cmd_data = '0;
  logic read, write;
  logic [AW-1:0] address;
  logic [DW-1:0] data_out;
  logic read_valid = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_error, busy;
  logic [DW-1:0] rsp_data;
  logic [DW-1:0] model_mem[4];
  logic [DW-1:0] slave_mem[4];
  int checks = 0;
  int errors = 0;

  avalon_master_sequencer #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_address(cmd_address), .cmd_data(cmd_data),
    .read(read), .write(write), .address(address), .data_out(data_out),
    .read_valid(read_valid), .data_in(data_in), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk("wr_ready_before", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = a; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("wr_strobe", write, 1);
    chk("wr_address", address, a);
    chk("wr_data", data_out, d);
    chk("wr_no_read", read, 0);
    chk("wr_no_rsp", rsp_valid, 0);
    chk("wr_ready_low", cmd_ready, 0);
    if (write) slave_mem[address] = data_out;
    model_mem[a] = d;
    @(negedge clk);
    chk("wr_strobe_done", write, 0);
    chk("wr_ready_after", cmd_ready, 1);
  endtask

  // lat: WAIT cycle in which the slave answers (0 = never); hold: cycles rsp_ready stays low
  task automatic do_read(input logic [AW-1:0] a, input int lat, input int hold, input bit queue_write,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    logic [DW-1:0] exp;
    int nwait;
    exp = lat == 0 ? '0 : model_mem[a];
    nwait = lat == 0 ? TO : lat;
    chk("rd_ready_before", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = a; cmd_data = $urandom;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rd_strobe", read, 1);
    chk("rd_address", address, a);
    chk("rd_ready_low", cmd_ready, 0);
    chk("rd_busy", busy, 1);
    for (int k = 1; k <= nwait; k++) begin
      @(negedge clk);
      chk("rd_strobe_done", read, 0);
      chk("rd_rsp_early", rsp_valid, 0);
      if (k == lat) begin
        read_valid = 1'b1;
        data_in = slave_mem[address];
      end
    end
    @(negedge clk);
    read_valid = 1'b0;
    data_in = $urandom;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, exp);
    chk("rsp_error", rsp_error, lat == 0);
    if (queue_write) begin
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = wa; cmd_data = wd;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, exp);
      chk("hold_ready", cmd_ready, 0);
      chk("hold_no_write", write, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", rsp_valid, 0);
    chk("rsp_idle_ready", cmd_ready, 1);
    if (queue_write) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("queued_write", write, 1);
      chk("queued_addr", address, wa);
      chk("queued_data", data_out, wd);
      if (write) slave_mem[address] = data_out;
      model_mem[wa] = wd;
      @(negedge clk);
      chk("queued_idle", cmd_ready, 1);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_address", address, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_error", rsp_error, 0);
    reset = 1'b0;
    @(negedge clk);
    do_write(2'd1, 32'h5);
    do_write(2'd0, 32'h12345678);
    do_read(2'd0, 1, 0, 1'b0, '0, '0);
    do_read(2'd1, 2, 5, 1'b1, 2'd3, 32'hCAFE0003);
    do_write(2'd2, 32'hBB);
    read_valid = 1'b1; data_in = 32'hAA;
    @(negedge clk);
    read_valid = 1'b0;
    chk("stray_no_rsp", rsp_valid, 0);
    chk("stray_idle", busy, 0);
    do_read(2'd2, 1, 0, 1'b0, '0, '0);
    @(negedge clk);
    chk("one_rsp_only", rsp_valid, 0);
`ifdef AVALON_MASTER_TIMEOUT_EN
    do_read(2'd1, 0, 1, 1'b0, '0, '0);
    do_read(2'd1, TO, 0, 1'b0, '0, '0);
`endif
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(AW'($urandom_range(0, 3)), $urandom);
      else
        do_read(AW'($urandom_range(0, 3)), $urandom_range(1, TO), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom);
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 2'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_wait", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    read_valid = 1'b1; data_in = 32'hDEAD;
    chk("mid_rst_idle", busy, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_read", read, 0);
    chk("mid_rst_address", address, 0);
    chk("mid_rst_data_out", data_out, 0);
    @(negedge clk);
    read_valid = 1'b0;
    chk("late_valid_rsp", rsp_valid, 0);
    chk("late_valid_data", rsp_data, 0);
    chk("late_valid_error", rsp_error, 0);
    chk("late_valid_idle", cmd_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
